fault_qualifier: RTL and testbench
==================================

# fault_qualifier

Upstream stage of the health-indicator fault latch: converts the raw, asynchronous fault comparator line into the qualified `true_fault` level the latch consumes. It synchronises the input and debounces it, so a fault must be stable for a set time before it is declared. It also detects intermittent faults: repeated short glitches inside a time window are declared a fault. A declared fault self-clears only after the line has been clean for a configurable period.

## Interface
- `DEBOUNCE_CYCLES`, 16: consecutive synchronised-high cycles required to declare a persistent fault (≥2).
- `CLEAR_CYCLES`, 64: consecutive synchronised-low cycles required to withdraw a declared fault (≥2).
- `GLITCH_LIMIT`, 4: rejected glitches within one window that declare an intermittent fault (≥1).
- `WINDOW_CYCLES`, 1024: length of the glitch-counting window in cycles (≥2).
- `clk`  in  1  system clock; the only clock.
- `reset`  in  1  asynchronous, active-high reset.
- `raw_fault`  in  1  raw fault line; asynchronous to `clk`.
- `true_fault`  out  1  qualified fault level, registered.
- `fault_cause`  out  2  cause code: 00 none, 01 persistent, 10 intermittent; 11 is never driven.
- `glitch_count`  out  $clog2(GLITCH_LIMIT+1)  glitches counted in the current window.

## Operation
- Reset asserted: all flops clear immediately. State is IDLE. `true_fault`=0, `fault_cause`=00, `glitch_count`=0. Synchroniser, cycle counter and window timer are 0.
- A 2-flop synchroniser produces `sync` from `raw_fault`. Only `sync` is used downstream of the synchroniser.
- Cycle counter `cnt` width is $clog2(max(DEBOUNCE_CYCLES,CLEAR_CYCLES)+1). It saturates and never wraps.
- IDLE: if `sync`=1, go to ARMING with `cnt`=1.
- ARMING, `sync`=1: increment `cnt`. When the incremented value equals DEBOUNCE_CYCLES, go to FAULT: `true_fault`=1, `fault_cause`=01.
- ARMING, `sync`=0: this is a glitch. Go to IDLE, set `cnt`=0, increment `glitch_count`. If the incremented value equals GLITCH_LIMIT, go to FAULT instead: `true_fault`=1, `fault_cause`=10.
- FAULT: if `sync`=0, go to CLEARING with `cnt`=1.
- CLEARING, `sync`=0: increment `cnt`. When it equals CLEAR_CYCLES, go to IDLE: `true_fault`=0, `fault_cause`=00.
- CLEARING, `sync`=1: return to FAULT with `cnt`=0. This is not counted as a glitch. The cause is unchanged.
- Window timer counts 0..WINDOW_CYCLES-1 and wraps. On wrap, `glitch_count`=0.
- Entry to FAULT clears both `glitch_count` and the window timer.
- Glitch reaching GLITCH_LIMIT on the same edge as a window wrap: the fault is declared, then the count is cleared.
- `glitch_count` never exceeds GLITCH_LIMIT.

## Timing
- `raw_fault` sampled high at edge N and held: `sync`=1 after edge N+1. `true_fault`=1 after edge N+1+DEBOUNCE_CYCLES (edge N+17 with defaults).
- Release: `raw_fault` sampled low at edge M and held: `true_fault`=0 after edge M+1+CLEAR_CYCLES.
- All outputs are registered and change only on `clk` edges or on reset.
- Reset mid-operation aborts any state, including FAULT. There is no memory of a fault across reset.

## Configuration
- `FAULT_GLITCH_DETECT_EN` defined: window timer, glitch counter and intermittent-fault path are built as described above.
- `FAULT_GLITCH_DETECT_EN` undefined:
  - A drop of `sync` in ARMING returns to IDLE with no side effect.
  - `glitch_count` is tied to 0.
  - `fault_cause` is only ever 00 or 01.
  - GLITCH_LIMIT and WINDOW_CYCLES are unused.

## Structure
- Package `fault_pkg`:
  - state enum: IDLE, ARMING, FAULT, CLEARING.
  - cause constants: CAUSE_NONE=2'b00, CAUSE_PERSIST=2'b01, CAUSE_INTERMIT=2'b10.
- Sub-module `fault_sync`: 2-flop synchroniser with async active-high reset to 0. It is kept separate so CDC tools can identify it.

## Test plan
- Persistent fault: reset, then `raw_fault`=1 held from edge 10. `true_fault` and `fault_cause`=01 after edge 27; `glitch_count` stays 0.
- Short pulse: `raw_fault` high for 5 cycles. `true_fault` stays 0; `glitch_count`=1.
- Intermittent fault: 4 pulses of 5 cycles, spaced 20 cycles apart, inside one window. `true_fault`=1 with `fault_cause`=10 on the 4th glitch; `glitch_count` returns to 0.
- Window expiry: 3 glitches, wait past the window wrap, then 3 more glitches. No fault; `glitch_count` reads 0 after the wrap and 3 at the end.
- Clear with interruption: after a fault, `raw_fault`=0 for 40 cycles, 1 for 2 cycles, then 0 held. `true_fault` stays 1 until 65 cycles after the final low sample.
- Reset mid-ARMING and mid-FAULT: pulse `reset` for 1 cycle. All outputs are 0 asynchronously; with `raw_fault` still high, full debounce restarts (16+1 edges).

Source files
------------

// File: rtl/fault_qualifier_pkg.sv
// Shared types and constants for the fault qualifier slice.
// Holds the FSM state encoding, cause codes and a constant-width helper.
package fault_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ARMING,
      FAULT,
      CLEARING
   } fault_state_t;

   localparam logic [1:0] CAUSE_NONE     = 2'b00;
   localparam logic [1:0] CAUSE_PERSIST  = 2'b01;
   localparam logic [1:0] CAUSE_INTERMIT = 2'b10;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/fault_qualifier_if.sv
// Raw fault line in, qualified fault level, cause and glitch count out.
// The master side drives raw_fault; the slave side is the qualifier.
interface fault_qualifier_if #(
   parameter int unsigned GLITCH_LIMIT = 4
);
   localparam int unsigned GCW = $clog2(GLITCH_LIMIT + 1);

   logic           raw_fault;
   logic           true_fault;
   logic [1:0]     fault_cause;
   logic [GCW-1:0] glitch_count;

   modport master (
      output raw_fault,
      input  true_fault,
      input  fault_cause,
      input  glitch_count
   );

   modport slave (
      input  raw_fault,
      output true_fault,
      output fault_cause,
      output glitch_count
   );
endinterface

// File: rtl/fault_qualifier_sync.sv
// Two-flop synchroniser for the asynchronous raw fault line.
// Kept as its own module so CDC tooling can recognise the crossing.
module fault_sync (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);
   logic meta;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end
endmodule

// File: rtl/fault_qualifier.sv
// Debounces the synchronised fault line into true_fault and withdraws it after a clean period.
// Intermittent-fault detection (window timer + glitch counter) is built only with FAULT_GLITCH_DETECT_EN.
module fault_qualifier
   import fault_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 16,
   parameter int unsigned CLEAR_CYCLES    = 64,
   parameter int unsigned GLITCH_LIMIT    = 4,
   parameter int unsigned WINDOW_CYCLES   = 1024
) (
   input logic              clk,
   input logic              reset,
   fault_qualifier_if.slave fq
);
   localparam int unsigned CNT_MAX = max_u(DEBOUNCE_CYCLES, CLEAR_CYCLES);
   localparam int unsigned CW      = $clog2(CNT_MAX + 1);
   localparam int unsigned GCW     = $clog2(GLITCH_LIMIT + 1);

   localparam logic [CW-1:0] DEB_C = CW'(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CLR_C = CW'(CLEAR_CYCLES);
   localparam logic [CW-1:0] SAT_C = CW'(CNT_MAX);

   if (DEBOUNCE_CYCLES < 2 || CLEAR_CYCLES < 2 || GLITCH_LIMIT < 1 || WINDOW_CYCLES < 2) begin : g_bad_cfg
      $error("fault_qualifier: illegal parameter set");
   end

   logic          sync;
   fault_state_t  state;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_inc;
   logic          true_fault_q;
   logic [1:0]    cause_q;
   logic          glitch_trip;

   fault_sync u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (fq.raw_fault),
      .q     (sync)
   );

   assign cnt_inc = (cnt == SAT_C) ? cnt : cnt + CW'(1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         cnt          <= '0;
         true_fault_q <= 1'b0;
         cause_q      <= CAUSE_NONE;
      end else begin
         case (state)
            IDLE: begin
               if (sync) begin
                  state <= ARMING;
                  cnt   <= CW'(1);
               end
            end
            ARMING: begin
               if (sync) begin
                  if (cnt_inc == DEB_C) begin
                     state        <= FAULT;
                     cnt          <= '0;
                     true_fault_q <= 1'b1;
                     cause_q      <= CAUSE_PERSIST;
                  end else begin
                     cnt <= cnt_inc;
                  end
               end else if (glitch_trip) begin
                  state        <= FAULT;
                  cnt          <= '0;
                  true_fault_q <= 1'b1;
                  cause_q      <= CAUSE_INTERMIT;
               end else begin
                  state <= IDLE;
                  cnt   <= '0;
               end
            end
            FAULT: begin
               if (!sync) begin
                  state <= CLEARING;
                  cnt   <= CW'(1);
               end
            end
            CLEARING: begin
               // A re-assertion while clearing is a fault continuation, not a glitch; cause is kept.
               if (sync) begin
                  state <= FAULT;
                  cnt   <= '0;
               end else if (cnt_inc == CLR_C) begin
                  state        <= IDLE;
                  cnt          <= '0;
                  true_fault_q <= 1'b0;
                  cause_q      <= CAUSE_NONE;
               end else begin
                  cnt <= cnt_inc;
               end
            end
            default: begin
               state <= IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

`ifdef FAULT_GLITCH_DETECT_EN
   localparam int unsigned    WW       = $clog2(WINDOW_CYCLES);
   localparam logic [WW-1:0]  WIN_LAST = WW'(WINDOW_CYCLES - 1);
   localparam logic [GCW-1:0] GL_C     = GCW'(GLITCH_LIMIT);

   logic [WW-1:0]  win;
   logic [GCW-1:0] gc;
   logic [GCW-1:0] gc_inc;
   logic           glitch;
   logic           fault_entry;

   assign gc_inc      = gc + GCW'(1);
   assign glitch      = (state == ARMING) && !sync;
   assign glitch_trip = glitch && (gc_inc == GL_C);
   assign fault_entry = glitch_trip || ((state == ARMING) && sync && (cnt_inc == DEB_C));

   // Fault entry outranks a coincident wrap; both leave the count at zero.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         win <= '0;
         gc  <= '0;
      end else if (fault_entry || (win == WIN_LAST)) begin
         win <= '0;
         gc  <= '0;
      end else begin
         win <= win + WW'(1);
         if (glitch) begin
            gc <= gc_inc;
         end
      end
   end

   assign fq.glitch_count = gc;
`else
   assign glitch_trip     = 1'b0;
   assign fq.glitch_count = '0;
`endif

   assign fq.true_fault  = true_fault_q;
   assign fq.fault_cause = cause_q;

endmodule

// File: tb/tb_fault_qualifier.sv
// Scoreboard bench for fault_qualifier: a run-length reference model queues expected outputs per edge.
// Scenario checks cover debounce latency, glitches, window wrap, interrupted clear and reset.
module tb_fault_qualifier;
   localparam int unsigned D   = 16;
   localparam int unsigned C   = 64;
   localparam int unsigned GL  = 4;
   localparam int unsigned W   = 1024;

`ifdef FAULT_GLITCH_DETECT_EN
   localparam bit GDET = 1'b1;
`else
   localparam bit GDET = 1'b0;
`endif

   typedef struct {
      int tf;
      int cause;
      int gc;
   } exp_t;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   fault_qualifier_if #(.GLITCH_LIMIT(GL)) fq ();

   fault_qualifier #(
      .DEBOUNCE_CYCLES (D),
      .CLEAR_CYCLES    (C),
      .GLITCH_LIMIT    (GL),
      .WINDOW_CYCLES   (W)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .fq    (fq.slave)
   );

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_bad    = 0;

   // reference model state
   int m_s1, m_s2, m_fault, m_cause, m_hr, m_lr, m_gc, m_win;

   task automatic check_eq(input string tag, input logic [31:0] got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic check_outs(input string tag, input int tf, input int cause, input int gc);
      check_eq({tag, ".true_fault"},   32'(fq.true_fault),   tf);
      check_eq({tag, ".fault_cause"},  32'(fq.fault_cause),  cause);
      check_eq({tag, ".glitch_count"}, 32'(fq.glitch_count), gc);
   endtask

   task automatic model_reset();
      m_s1 = 0; m_s2 = 0; m_fault = 0; m_cause = 0;
      m_hr = 0; m_lr = 0; m_gc = 0; m_win = 0;
   endtask

   task automatic model_step();
      int s;
      bit wrap, entered, glitch;
      s       = m_s2;
      wrap    = (m_win == W - 1);
      entered = 1'b0;
      glitch  = 1'b0;
      if (m_fault == 0) begin
         if (s != 0) begin
            m_hr++;
            if (m_hr == D) begin
               m_fault = 1; m_cause = 1; entered = 1'b1;
            end
         end else if (m_hr > 0) begin
            m_hr = 0;
            if (GDET) begin
               glitch = 1'b1;
               if (m_gc + 1 == GL) begin
                  m_fault = 1; m_cause = 2; entered = 1'b1;
               end
            end
         end
      end else begin
         if (s != 0) m_lr = 0;
         else begin
            m_lr++;
            if (m_lr == C) begin
               m_fault = 0; m_cause = 0; m_lr = 0; m_hr = 0;
            end
         end
      end
      if (entered) begin
         m_hr = 0; m_lr = 0;
      end
      if (GDET) begin
         if (entered || wrap) begin
            m_gc = 0; m_win = 0;
         end else begin
            m_win++;
            if (glitch) m_gc++;
         end
      end
      m_s2 = m_s1;
      m_s1 = int'(fq.raw_fault);
   endtask

   task automatic tick();
      exp_t e;
      @(posedge clk);
      if (reset) model_reset();
      else model_step();
      exp_q.push_back('{tf: m_fault, cause: m_cause, gc: m_gc});
      @(negedge clk);
      e = exp_q.pop_front();
      check_outs("sb", e.tf, e.cause, e.gc);
   endtask

   task automatic pulse();
      fq.raw_fault = 1'b1;
      repeat (5) tick();
      fq.raw_fault = 1'b0;
      repeat (15) tick();
   endtask

   task automatic reset_pulse(input string tag);
      reset = 1'b1;
      #1;
      check_outs(tag, 0, 0, 0);
      model_reset();
      tick();
      reset = 1'b0;
   endtask

   initial begin
      fq.raw_fault = 1'b0;
      model_reset();
      #2 reset = 1'b1;
      #1;
      check_outs("reset", 0, 0, 0);
      tick();
      tick();
      reset = 1'b0;

      // persistent fault: high sampled at edge 10, declared after edge 27
      repeat (9) tick();
      fq.raw_fault = 1'b1;
      repeat (17) tick();
      check_eq("persist.edge26", 32'(fq.true_fault), 0);
      tick();
      check_outs("persist.edge27", 1, 1, 0);
      fq.raw_fault = 1'b0;
      repeat (65) tick();
      check_eq("release.edge64", 32'(fq.true_fault), 1);
      tick();
      check_outs("release.edge65", 0, 0, 0);

      // single short pulse
      pulse();
      check_outs("short", 0, 0, GDET ? 1 : 0);
      repeat (1030) tick();
      check_eq("short.wrap", 32'(fq.glitch_count), 0);

      // four pulses inside one window
      repeat (3) pulse();
      check_outs("intermit.3", 0, 0, GDET ? 3 : 0);
      pulse();
      check_outs("intermit.4", GDET ? 1 : 0, GDET ? 2 : 0, 0);
      repeat (70) tick();
      check_outs("intermit.clear", 0, 0, 0);

      // window expiry between two groups of three
      repeat (3) pulse();
      check_eq("window.pre", 32'(fq.glitch_count), GDET ? 3 : 0);
      repeat (1000) tick();
      check_eq("window.wrap", 32'(fq.glitch_count), 0);
      repeat (3) pulse();
      check_outs("window.post", 0, 0, GDET ? 3 : 0);

      // clear interrupted by a 2-cycle re-assertion
      fq.raw_fault = 1'b1;
      repeat (20) tick();
      check_outs("intr.fault", 1, 1, 0);
      fq.raw_fault = 1'b0;
      repeat (40) tick();
      fq.raw_fault = 1'b1;
      repeat (2) tick();
      check_eq("intr.held", 32'(fq.true_fault), 1);
      fq.raw_fault = 1'b0;
      repeat (65) tick();
      check_outs("intr.edge64", 1, 1, 0);
      tick();
      check_outs("intr.edge65", 0, 0, 0);

      // reset mid-ARMING, then mid-FAULT, with raw_fault held high
      fq.raw_fault = 1'b1;
      repeat (8) tick();
      reset_pulse("rst.arming");
      repeat (17) tick();
      check_eq("rst.arming.edge17", 32'(fq.true_fault), 0);
      tick();
      check_outs("rst.arming.edge18", 1, 1, 0);
      repeat (5) tick();
      reset_pulse("rst.fault");
      repeat (17) tick();
      check_eq("rst.fault.edge17", 32'(fq.true_fault), 0);
      tick();
      check_outs("rst.fault.edge18", 1, 1, 0);
      fq.raw_fault = 1'b0;
      repeat (70) tick();
      check_outs("final", 0, 0, 0);

      $display("test done: total=%0d bad=%0d", n_checks, n_bad);
      $finish;
   end
endmodule
